// File: rtl/display_scan.sv
// display_scan: time-multiplexed scanner for a common-anode multi-digit
// 7-segment display. Steps through the digits of a packed hex value one
// slot at a time, blanks all anodes for GUARD cycles at each slot start,
// and applies newly loaded values only at frame boundaries.
//
// Optional build macro: DISPLAY_SCAN_LZB_EN enables leading-zero blanking.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   value    packed hex digits, nibble i -> digit i (digit 0 = bits [3:0])
//   load     capture value into the pending buffer this cycle
//   num      nibble of the active digit, to the 7-segment decoder
//   an       active-low anode enables, at most one low
//   digit    index of the active digit
//   updated  one-cycle pulse when the pending value becomes displayed
module display_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              digit,
  output logic                    updated
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [VW-1:0] shown_q, shown_d;
  logic [VW-1:0] pend_val_q, pend_val_d;
  logic          pending_q, pending_d;
  logic          updated_q, updated_d;

  logic tick;
  logic wrap;
  logic in_guard;
  logic blank;

  // Next-state: free-running scan plus double-buffered value update.
  always_comb begin
    tick       = (presc_q == PW'(REFRESH_DIV - 1));
    wrap       = tick && (digit_q == 3'(NUM_DIGITS - 1));
    presc_d    = tick ? '0 : presc_q + PW'(1);
    digit_d    = digit_q;
    shown_d    = shown_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    updated_d  = 1'b0;

    if (tick) begin
      digit_d = (digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
    end

    if (wrap) begin
      // A load coinciding with the wrap bypasses the pending buffer.
      if (load) begin
        shown_d   = value;
        pending_d = 1'b0;
        updated_d = 1'b1;
      end else if (pending_q) begin
        shown_d   = pend_val_q;
        pending_d = 1'b0;
        updated_d = 1'b1;
      end
    end else if (load) begin
      pend_val_d = value;
      pending_d  = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      digit_q    <= '0;
      shown_q    <= '0;
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      updated_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      shown_q    <= shown_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      updated_q  <= updated_d;
    end
  end

  // Anti-ghosting guard window at the start of every slot.
  generate
    if (GUARD > 0) begin : g_guard
      assign in_guard = (presc_q < PW'(GUARD));
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

`ifdef DISPLAY_SCAN_LZB_EN
  // Digit i > 0 is blanked when it and every higher nibble are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above && (shown_q[4*i +: 4] == 4'h0);
      if ((digit_q == 3'(i)) && zero_above) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Active digit nibble, selected without ever indexing past the value.
  always_comb begin
    num = 4'h0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit_q == 3'(i)) num = shown_q[4*i +: 4];
    end
  end

  // Active-low anodes: one low outside the guard window unless blanked.
  always_comb begin
    an = '1;
    if (!in_guard && !blank) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (digit_q == 3'(i)) an[i] = 1'b0;
      end
    end
  end

  assign digit   = digit_q;
  assign updated = updated_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed self-checking bench for display_scan with
// NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1. Cycle n counts rising edges since
// the most recent reset release; with these parameters presc = n%4 and
// digit = (n/4)%4, so the first frame wrap lands on cycle 16.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  num;
  logic [3:0]  an;
  logic [2:0]  digit;
  logic        updated;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int upd_cnt;

`ifdef DISPLAY_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  always #5 clk = ~clk;

  display_scan #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .GUARD      (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .value  (value),
    .load   (load),
    .num    (num),
    .an     (an),
    .digit  (digit),
    .updated(updated)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to cycle n, sampling 1 time unit after the rising edge.
  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Expected anodes at cycle n when only digits below 'lit' are visible.
  function automatic logic [3:0] an_exp(input int n, input int lit);
    int d;
    logic [3:0] one;
    one = 4'b0001;
    d   = (n / 4) % 4;
    if ((n % 4) == 0 || d >= lit) return 4'hF;
    return ~(one << d);
  endfunction

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_num", num, 0);
    chk("rst_digit", digit, 0);
    chk("rst_an", an, 4'hF);
    chk("rst_upd", updated, 0);
    rst = 1'b0;
    cyc = 0;

    // Scan sequence over the first frame; load 1234 captured at cycle 2.
    for (int n = 1; n <= 15; n++) begin
      run_to(n);
      chk("t1_an", an, an_exp(n, LZB ? 1 : 4));
      chk("t1_num", num, 0);
      chk("t1_upd", updated, 0);
      if (n == 1) begin
        load  = 1'b1;
        value = 16'h1234;
      end else begin
        load = 1'b0;
      end
    end

    run_to(16);
    chk("t2_upd", updated, 1);
    chk("t2_digit", digit, 0);
    chk("t2_num0", num, 4'h4);
    chk("t2_guard", an, 4'hF);
    run_to(17);
    chk("t2_upd_off", updated, 0);
    chk("t2_an0", an, 4'hE);
    run_to(21);
    chk("t2_num1", num, 4'h3);
    chk("t2_dig1", digit, 1);
    run_to(25);
    chk("t2_num2", num, 4'h2);
    run_to(29);
    chk("t2_num3", num, 4'h1);
    chk("t2_an3", an, 4'h7);
    run_to(32);
    chk("t2_no_reupd", updated, 0);
    chk("t2_num_wrap", num, 4'h4);

    // Two loads in one frame: the last wins, one update pulse at cycle 48.
    upd_cnt = 0;
    for (int n = 33; n <= 63; n++) begin
      run_to(n);
      if (updated) upd_cnt++;
      if (n == 44) chk("t3_no_tear", num, 4'h1);
      if (n == 48) begin
        chk("t3_upd", updated, 1);
        chk("t3_num0", num, 4'hB);
      end
      if (n == 52) chk("t3_num1", num, 4'h5);
      if (n == 56) chk("t3_num2", num, 4'hB);
      if (n == 60) chk("t3_num3", num, 4'h5);
      if (n == 34) begin
        load  = 1'b1;
        value = 16'hAAAA;
      end else if (n == 40) begin
        load  = 1'b1;
        value = 16'h5B5B;
      end else begin
        load = 1'b0;
      end
    end
    chk("t3_upd_cnt", upd_cnt, 1);

    // Load coincident with the wrap tick bypasses the pending buffer.
    chk("t4_pre_digit", digit, 3);
    load  = 1'b1;
    value = 16'hF00D;
    run_to(64);
    load = 1'b0;
    chk("t4_digit", digit, 0);
    chk("t4_num", num, 4'hD);
    chk("t4_upd", updated, 1);
    upd_cnt = 0;
    for (int n = 65; n <= 95; n++) begin
      run_to(n);
      if (updated) upd_cnt++;
      if (n == 68) chk("t4_num1", num, 4'h0);
      if (n == 76) chk("t4_num3", num, 4'hF);
      if (n == 80) chk("t4_num_next", num, 4'hD);
    end
    chk("t4_upd_cnt", upd_cnt, 0);

    // Reset mid-frame discards the pending value.
    run_to(97);
    load  = 1'b1;
    value = 16'h1234;
    run_to(98);
    load = 1'b0;
    run_to(105);
    chk("t5_pre_digit", digit, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_num", num, 0);
    chk("t5_digit", digit, 0);
    chk("t5_an", an, 4'hF);
    chk("t5_upd", updated, 0);
    rst = 1'b0;
    cyc = 0;
    upd_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      run_to(n);
      if (updated) upd_cnt++;
      if (n == 16) chk("t5_num_wrap", num, 0);
    end
    chk("t5_upd_cnt", upd_cnt, 0);

    // Leading-zero handling with 0042, then 0000.
    run_to(21);
    load  = 1'b1;
    value = 16'h0042;
    run_to(22);
    load = 1'b0;
    run_to(33);
    chk("t6_an0", an, 4'hE);
    chk("t6_num0", num, 4'h2);
    load  = 1'b1;
    value = 16'h0000;
    run_to(34);
    load = 1'b0;
    run_to(37);
    chk("t6_an1", an, 4'hD);
    chk("t6_num1", num, 4'h4);
    run_to(41);
    chk("t6_an2", an, LZB ? 4'hF : 4'hB);
    chk("t6_num2", num, 4'h0);
    run_to(45);
    chk("t6_an3", an, LZB ? 4'hF : 4'h7);
    chk("t6_num3", num, 4'h0);
    run_to(48);
    chk("t6_zero_upd", updated, 1);
    run_to(49);
    chk("t6_zero_an0", an, 4'hE);
    chk("t6_zero_num0", num, 4'h0);
    run_to(53);
    chk("t6_zero_an1", an, LZB ? 4'hF : 4'hD);
    run_to(57);
    chk("t6_zero_an2", an, LZB ? 4'hF : 4'hB);
    run_to(61);
    chk("t6_zero_an3", an, LZB ? 4'hF : 4'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
